network_argmax: RTL and testbench
=================================

Name: network_argmax

Overview:
- Classifier stage directly downstream of network_top.
- Captures the ten 16-bit output-neuron values (out0..out9) on a start strobe, then scans them sequentially.
- Reports the winning class index, its value, and the margin to the runner-up.
- Keeps running total/correct counters against a supplied label, for accuracy measurement over a test set.

Parameters:
- DATA_W, 16, width of each neuron output value.
- NUM_OUT, 10, number of output neurons; index width is clog2(NUM_OUT) = 4.
- SIGNED_CMP, 0, 0 = compare values as unsigned (sigmoid outputs); 1 = compare as two's complement.
- CNT_W, 16, width of the total and correct counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous assert, active-low (0 = reset).
- start  in  1  single-cycle request; sampled only in IDLE.
- out0..out9  in  DATA_W each  neuron outputs from network_top; sampled on the accepted start edge.
- label  in  4  expected class; sampled with start.
- clear  in  1  synchronous clear of both counters.
- busy  out  1  high in SCAN and FINISH.
- done  out  1  one-cycle pulse; result outputs valid from this cycle on.
- class_out  out  4  index of the maximum value.
- max_out  out  DATA_W  maximum value.
- margin_out  out  DATA_W  max minus second-largest; unsigned.
- correct  out  1  class_out == sampled label; valid with done.
- total_count  out  CNT_W  completed classifications.
- correct_count  out  CNT_W  completed classifications where correct = 1.

Behaviour:
- While rst = 0: FSM in IDLE; busy, done, correct = 0; class_out, max_out, margin_out = 0; both counters = 0; capture registers = 0.
- Reset deasserted mid-scan: the operation is aborted, with no done and no counter update.
- FSM states: IDLE, SCAN, FINISH.
- Edge E0, IDLE with start = 1:
  - Latch v[0..9] and label.
  - best = v0, best_idx = 0, second = type minimum (0 if unsigned, 0x8000 if signed), idx = 1.
  - Go to SCAN.
- Edges E1..E9, SCAN compares v[idx]:
  - If v[idx] > best: second <= best; best <= v[idx]; best_idx <= idx.
  - Else if v[idx] > second: second <= v[idx].
  - idx increments. On the compare with idx = 9, go to FINISH.
- Ties: strict ">" means the lowest index wins. An equal value still updates second, so the margin becomes 0.
- Edge E10, FINISH to IDLE; registers update:
  - class_out = best_idx; max_out = best; margin_out = best - second (modulo 2^DATA_W, always fits).
  - correct = (best_idx == latched label).
  - done <= 1 for exactly one cycle.
  - total_count += 1; correct_count += correct.
- Latency: start edge to done = 10 cycles; throughput is one classification per 11 cycles. A start during the done cycle is accepted, because that cycle is IDLE.
- start while busy: ignored, with no queueing.
- Inputs out0..out9 may change after E0 without effect.
- Result outputs hold their values until the next FINISH.
- label values 10..15 never match, so correct = 0.
- Counters saturate at 2^CNT_W-1 and do not wrap. correct_count never exceeds total_count.
- clear = 1: both counters go to 0 on the next edge. If clear coincides with FINISH, clear wins and the counters become 0. class_out, max_out and done still update normally.
- Comparison signedness is set by SIGNED_CMP only. The subtraction for margin_out uses the same interpretation.

Decomposition:
- Shared package nn_pkg holds:
  - NUM_OUT, DATA_W, IDX_W = 4
  - FSM state encoding (IDLE = 0, SCAN = 1, FINISH = 2)
  - the signed/unsigned minimum constants
- One sub-module, argmax_cmp: combinational greater-than honouring SIGNED_CMP. It is instantiated twice, once for the best comparison and once for the second comparison.

Test Plan:
1. Unsigned, outs = {0x0100, 0x0200, …, 0x0A00} (increasing), label = 9, start at E0:
   - busy high for 10 cycles, then done at E10.
   - class_out = 9, max_out = 0x0A00, margin_out = 0x0100, correct = 1, total = 1, correct_count = 1.
2. Tie, out3 = out7 = 0x7FFF, others 0x0010, label = 7:
   - class_out = 3, margin_out = 0, correct = 0, correct_count unchanged.
3. SIGNED_CMP = 1, all outs = 0xFFFF except out5 = 0x0001:
   - class_out = 5, max_out = 0x0001, margin_out = 0x0002.
   - The same vector with SIGNED_CMP = 0 gives class_out = 0 and margin_out = 0.
4. start re-asserted during SCAN with different outs:
   - Ignored; the result matches the first vector and exactly one done pulse occurs.
   - start during the done cycle is accepted: the next done follows 10 cycles later.
5. rst pulsed low at E5 of a scan:
   - All outputs go to 0 asynchronously, no done is produced, and the counters stay 0.
   - A new start after release completes normally.
6. clear asserted in the FINISH cycle after three prior classifications (total = 3):
   - total_count = 0 and correct_count = 0, and done still pulses.
   - Forced saturation: preload totals to 0xFFFF, run one more classification, and total_count remains 0xFFFF.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the network_argmax classifier stage.
//   NUM_OUT / DATA_W / IDX_W : default geometry of the output layer
//   state_e                  : argmax FSM state encoding
//   MinUnsigned / MinSigned  : smallest representable value, used to seed the runner-up
package nn_pkg;

    localparam int unsigned NUM_OUT = 10;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScan   = 2'd1,
        StFinish = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] MinUnsigned = '0;
    localparam logic [DATA_W-1:0] MinSigned   = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/argmax_cmp.sv
// Combinational strict greater-than comparator.
//   a, b : operands
//   gt   : 1 when a > b, two's complement if SIGNED_CMP else unsigned
module argmax_cmp #(
    parameter int unsigned DATA_W     = 16,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    always_comb begin
        gt = 1'b0;
        if (SIGNED_CMP) begin
            gt = $signed(a) > $signed(b);
        end else begin
            gt = a > b;
        end
    end

endmodule

// File: rtl/network_argmax.sv
// Argmax classifier for the ten output neurons of network_top.
// Captures out0..out9 and label on an accepted start, scans the values one per cycle,
// then publishes the winning index, its value, the margin to the runner-up and whether
// the index matched the label. Keeps saturating total/correct counters.
//   clk, rst (async, active-low)  : clock and reset
//   start, label, out0..out9      : request, expected class, neuron values
//   clear                         : synchronous clear of both counters
//   busy, done                    : scan in progress / one-cycle result strobe
//   class_out, max_out, margin_out, correct : result, held until the next finish
//   total_count, correct_count    : accuracy counters
module network_argmax
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W     = nn_pkg::DATA_W,
    parameter int unsigned NUM_OUT    = nn_pkg::NUM_OUT,
    parameter bit          SIGNED_CMP = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] out0,
    input  logic [DATA_W-1:0] out1,
    input  logic [DATA_W-1:0] out2,
    input  logic [DATA_W-1:0] out3,
    input  logic [DATA_W-1:0] out4,
    input  logic [DATA_W-1:0] out5,
    input  logic [DATA_W-1:0] out6,
    input  logic [DATA_W-1:0] out7,
    input  logic [DATA_W-1:0] out8,
    input  logic [DATA_W-1:0] out9,
    input  logic [IDX_W-1:0]  label,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_out,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] margin_out,
    output logic              correct,
    output logic [CNT_W-1:0]  total_count,
    output logic [CNT_W-1:0]  correct_count
);

    localparam logic [DATA_W-1:0] MinVal =
        SIGNED_CMP ? DATA_W'(MinSigned) : DATA_W'(MinUnsigned);

    state_e state_q, state_d;

    // Candidates out1..out9; the queue shifts down so the current candidate is always v_q[0].
    logic [DATA_W-1:0] v_q [NUM_OUT-1];
    logic [DATA_W-1:0] in_vec [NUM_OUT-1];
    logic [DATA_W-1:0] best_q, second_q;
    logic [IDX_W-1:0]  best_idx_q, idx_q, label_q;
    logic [IDX_W-1:0]  class_q;
    logic [DATA_W-1:0] max_q, margin_q;
    logic              done_q, correct_q;
    logic [CNT_W-1:0]  total_q, corr_q;

    logic load, scan_en, fin, hit;
    logic gt_best, gt_second;

    argmax_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp_best (
        .a  (v_q[0]),
        .b  (best_q),
        .gt (gt_best)
    );

    argmax_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp_second (
        .a  (v_q[0]),
        .b  (second_q),
        .gt (gt_second)
    );

    always_comb begin
        in_vec[0] = out1;
        in_vec[1] = out2;
        in_vec[2] = out3;
        in_vec[3] = out4;
        in_vec[4] = out5;
        in_vec[5] = out6;
        in_vec[6] = out7;
        in_vec[7] = out8;
        in_vec[8] = out9;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StScan;
            StScan:   if (idx_q == IDX_W'(NUM_OUT - 1)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy    = (state_q != StIdle);
        load    = (state_q == StIdle) && start;
        scan_en = (state_q == StScan);
        fin     = (state_q == StFinish);
        hit     = (best_idx_q == label_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_OUT) - 1; i++) v_q[i] <= '0;
            best_q     <= '0;
            second_q   <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            label_q    <= '0;
            class_q    <= '0;
            max_q      <= '0;
            margin_q   <= '0;
            correct_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= fin;
            if (load) begin
                v_q        <= in_vec;
                label_q    <= label;
                best_q     <= out0;
                best_idx_q <= '0;
                second_q   <= MinVal;
                idx_q      <= IDX_W'(1);
            end else if (scan_en) begin
                for (int i = 0; i < int'(NUM_OUT) - 2; i++) v_q[i] <= v_q[i+1];
                // Strict compare keeps the lowest index on ties; an equal value still
                // lands in second, which drives the margin to zero.
                if (gt_best) begin
                    second_q   <= best_q;
                    best_q     <= v_q[0];
                    best_idx_q <= idx_q;
                end else if (gt_second) begin
                    second_q <= v_q[0];
                end
                idx_q <= idx_q + IDX_W'(1);
            end
            if (fin) begin
                class_q   <= best_idx_q;
                max_q     <= best_q;
                margin_q  <= best_q - second_q;
                correct_q <= hit;
            end
        end
    end

    // Saturating counters; clear has priority over a coincident finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
            corr_q  <= '0;
        end else if (clear) begin
            total_q <= '0;
            corr_q  <= '0;
        end else if (fin) begin
            if (total_q != '1) total_q <= total_q + CNT_W'(1);
            if (hit && corr_q != '1) corr_q <= corr_q + CNT_W'(1);
        end
    end

    assign done          = done_q;
    assign class_out     = class_q;
    assign max_out       = max_q;
    assign margin_out    = margin_q;
    assign correct       = correct_q;
    assign total_count   = total_q;
    assign correct_count = corr_q;

endmodule

// File: tb/tb_network_argmax.sv
module tb_network_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [3:0]  label;
    logic [15:0] outs [10];

    logic        busy, done, correct;
    logic [3:0]  class_out;
    logic [15:0] max_out, margin_out, total_count, correct_count;

    logic        busy_s, done_s, correct_s;
    logic [3:0]  class_s;
    logic [15:0] max_s, margin_s, total_s, ccount_s;

    logic        busy_n, done_n, correct_n;
    logic [3:0]  class_n;
    logic [15:0] max_n, margin_n;
    logic [1:0]  total_n, ccount_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    network_argmax u_dut (
        .clk(clk), .rst(rst), .start(start),
        .out0(outs[0]), .out1(outs[1]), .out2(outs[2]), .out3(outs[3]), .out4(outs[4]),
        .out5(outs[5]), .out6(outs[6]), .out7(outs[7]), .out8(outs[8]), .out9(outs[9]),
        .label(label), .clear(clear), .busy(busy), .done(done), .class_out(class_out),
        .max_out(max_out), .margin_out(margin_out), .correct(correct),
        .total_count(total_count), .correct_count(correct_count)
    );

    network_argmax #(.SIGNED_CMP(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start),
        .out0(outs[0]), .out1(outs[1]), .out2(outs[2]), .out3(outs[3]), .out4(outs[4]),
        .out5(outs[5]), .out6(outs[6]), .out7(outs[7]), .out8(outs[8]), .out9(outs[9]),
        .label(label), .clear(clear), .busy(busy_s), .done(done_s), .class_out(class_s),
        .max_out(max_s), .margin_out(margin_s), .correct(correct_s),
        .total_count(total_s), .correct_count(ccount_s)
    );

    // Narrow counters make saturation reachable in a few classifications.
    network_argmax #(.CNT_W(2)) u_dut_n (
        .clk(clk), .rst(rst), .start(start),
        .out0(outs[0]), .out1(outs[1]), .out2(outs[2]), .out3(outs[3]), .out4(outs[4]),
        .out5(outs[5]), .out6(outs[6]), .out7(outs[7]), .out8(outs[8]), .out9(outs[9]),
        .label(label), .clear(clear), .busy(busy_n), .done(done_n), .class_out(class_n),
        .max_out(max_n), .margin_out(margin_n), .correct(correct_n),
        .total_count(total_n), .correct_count(ccount_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 10; i++) outs[i] = v;
    endtask

    task automatic set_ramp(input bit up);
        for (int i = 0; i < 10; i++) outs[i] = up ? 16'((i + 1) << 8) : 16'((10 - i) << 8);
    endtask

    // Start a classification and wait (bounded) for done; checks start-to-done latency.
    task automatic go();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            step();
            n++;
        end
        check("latency", n, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int pulses;
        rst   = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        label = 4'd0;
        set_all(16'h0);
        step();
        step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_class", class_out, 0);
        check("rst_max", max_out, 0);
        check("rst_margin", margin_out, 0);
        check("rst_correct", correct, 0);
        check("rst_total", total_count, 0);
        check("rst_ccount", correct_count, 0);
        rst = 1'b1;
        step();

        // 1: increasing ramp, busy for 10 cycles then done
        set_ramp(1'b1);
        label = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("t1_busy_done", {busy, done}, 2'b10);
            step();
        end
        check("t1_done", {busy, done}, 2'b01);
        check("t1_class", class_out, 9);
        check("t1_max", max_out, 16'h0A00);
        check("t1_margin", margin_out, 16'h0100);
        check("t1_correct", correct, 1);
        check("t1_total", total_count, 1);
        check("t1_ccount", correct_count, 1);
        step();
        check("t1_done_pulse", done, 0);
        check("t1_hold_class", class_out, 9);

        // 2: tie between out3 and out7, lowest index wins, margin 0
        set_all(16'h0010);
        outs[3] = 16'h7FFF;
        outs[7] = 16'h7FFF;
        label = 4'd7;
        go();
        check("t2_class", class_out, 3);
        check("t2_max", max_out, 16'h7FFF);
        check("t2_margin", margin_out, 0);
        check("t2_correct", correct, 0);
        check("t2_total", total_count, 2);
        check("t2_ccount", correct_count, 1);

        // 3: signed vs unsigned interpretation of the same vector
        set_all(16'hFFFF);
        outs[5] = 16'h0001;
        label = 4'd5;
        go();
        check("t3s_class", class_s, 5);
        check("t3s_max", max_s, 16'h0001);
        check("t3s_margin", margin_s, 16'h0002);
        check("t3s_correct", correct_s, 1);
        check("t3u_class", class_out, 0);
        check("t3u_max", max_out, 16'hFFFF);
        check("t3u_margin", margin_out, 0);
        check("t3u_correct", correct, 0);

        // 4: start while busy is ignored; inputs changing after capture have no effect
        set_ramp(1'b0);
        label = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        set_ramp(1'b1);
        label = 4'd9;
        e = 0;
        repeat (3) begin
            step();
            e++;
        end
        start = 1'b1;
        step();
        e++;
        start = 1'b0;
        while (!done && e < 30) begin
            step();
            e++;
        end
        check("t4_latency", e, 10);
        check("t4_class", class_out, 0);
        check("t4_max", max_out, 16'h0A00);
        check("t4_margin", margin_out, 16'h0100);
        check("t4_correct", correct, 1);
        // start in the done cycle is accepted
        go();
        check("t4b_class", class_out, 9);
        check("t4b_correct", correct, 1);
        check("t4_total", total_count, 5);
        check("t4_ccount", correct_count, 3);

        // 5: asynchronous reset mid-scan aborts the operation
        set_ramp(1'b1);
        label = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #2;
        rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_class", class_out, 0);
        check("t5_max", max_out, 0);
        check("t5_margin", margin_out, 0);
        check("t5_correct", correct, 0);
        check("t5_total", total_count, 0);
        check("t5_ccount", correct_count, 0);
        step();
        rst = 1'b1;
        pulses = 0;
        repeat (12) begin
            step();
            if (done) pulses++;
        end
        check("t5_no_done", pulses, 0);
        check("t5_total_idle", total_count, 0);
        go();
        check("t5_class_after", class_out, 9);
        check("t5_total_after", total_count, 1);

        // 6: clear coinciding with finish wins over the increment
        go();
        go();
        check("t6_total3", total_count, 3);
        check("t6_ccount3", correct_count, 3);
        set_ramp(1'b0);
        label = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("t6_finish_busy", busy, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t6_done", done, 1);
        check("t6_class", class_out, 0);
        check("t6_total", total_count, 0);
        check("t6_ccount", correct_count, 0);
        step();
        check("t6_total_hold", total_count, 0);

        // Saturation on the 2-bit counter instance
        set_ramp(1'b1);
        label = 4'd9;
        repeat (3) go();
        check("sat_total3", total_n, 3);
        check("sat_ccount3", ccount_n, 3);
        go();
        check("sat_total", total_n, 3);
        check("sat_ccount", ccount_n, 3);
        check("sat_wide_total", total_count, 4);
        label = 4'd12;
        go();
        check("lbl_oob_correct", correct, 0);
        check("lbl_oob_ccount", correct_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
